// File: rtl/ps2_keycode.sv
// PS/2 keyboard receiver: synchronizes and filters the PS/2 lines, frames 11-bit packets,
// and maps a small set of set-2 scan codes to a held HID usage code.
module ps2_keycode #(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned FILT_LEN       = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] keycode,
  output logic       key_valid,
  output logic       frame_err
);

  localparam int unsigned FW = $clog2(FILT_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FiltMax = FW'(FILT_LEN - 1);
  localparam logic [TW-1:0] ToMax   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] ToSat   = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  logic          r_clk_s1, r_clk_s2;
  logic          r_dat_s1, r_dat_s2;
  logic          r_filt, r_filt_d;
  logic [FW-1:0] r_filt_cnt;
  state_e        r_state;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_parity;
  logic [TW-1:0] r_to_cnt;
  logic          r_e0, r_f0;
  logic [7:0]    r_keycode;
  logic          r_key_valid;
  logic          r_frame_err;

  logic       w_bit_edge;
  logic       w_byte_ok;
  logic [7:0] w_mapped;
  logic [7:0] w_next_key;

  function automatic logic [7:0] map_code(input logic i_ext, input logic [7:0] i_code);
    logic [7:0] w_usage;
    w_usage = 8'h00;
    if (!i_ext) begin
      case (i_code)
        8'h1D:   w_usage = 8'h1A;
        8'h1C:   w_usage = 8'h04;
        8'h1B:   w_usage = 8'h16;
        8'h23:   w_usage = 8'h07;
        8'h29:   w_usage = 8'h2C;
        8'h5A:   w_usage = 8'h28;
        default: w_usage = 8'h00;
      endcase
    end else begin
      case (i_code)
        8'h75:   w_usage = 8'h52;
        8'h72:   w_usage = 8'h51;
        8'h6B:   w_usage = 8'h50;
        8'h74:   w_usage = 8'h4F;
        default: w_usage = 8'h00;
      endcase
    end
    return w_usage;
  endfunction

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
      r_filt     <= 1'b1;
      r_filt_d   <= 1'b1;
      r_filt_cnt <= '0;
    end else begin
      r_clk_s1 <= PS2_CLK;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= PS2_DAT;
      r_dat_s2 <= r_dat_s1;
      r_filt_d <= r_filt;
      // Level flips only after FILT_LEN consecutive samples disagree with it.
      if (r_clk_s2 == r_filt) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FiltMax) begin
        r_filt     <= r_clk_s2;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + FW'(1);
      end
    end
  end

  assign w_bit_edge = r_filt_d & ~r_filt;
  assign w_byte_ok  = (^{r_shift, r_parity}) & r_dat_s2;
  assign w_mapped   = map_code(r_e0, r_shift);

  always_comb begin
    w_next_key = r_keycode;
    if (w_mapped != 8'h00) begin
      if (!r_f0) begin
        w_next_key = w_mapped;
      end else if (w_mapped == r_keycode) begin
        w_next_key = 8'h00;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state     <= StIdle;
      r_bit_cnt   <= '0;
      r_shift     <= 8'h00;
      r_parity    <= 1'b0;
      r_to_cnt    <= '0;
      r_e0        <= 1'b0;
      r_f0        <= 1'b0;
      r_keycode   <= 8'h00;
      r_key_valid <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      r_frame_err <= 1'b0;

      if (w_bit_edge) begin
        r_to_cnt <= '0;
      end else if (r_to_cnt != ToSat) begin
        r_to_cnt <= r_to_cnt + TW'(1);
      end

      case (r_state)
        StIdle: begin
          if (w_bit_edge) begin
            if (!r_dat_s2) begin
              r_state   <= StData;
              r_bit_cnt <= '0;
            end else begin
              r_frame_err <= 1'b1;
            end
          end
        end
        StData: begin
          if (w_bit_edge) begin
            r_shift   <= {r_dat_s2, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_state <= StParity;
            end
          end
        end
        StParity: begin
          if (w_bit_edge) begin
            r_parity <= r_dat_s2;
            r_state  <= StStop;
          end
        end
        StStop: begin
          if (w_bit_edge) begin
            r_state <= StIdle;
            if (!w_byte_ok) begin
              r_frame_err <= 1'b1;
            end else if (r_shift == 8'hE0) begin
              r_e0 <= 1'b1;
            end else if (r_shift == 8'hF0) begin
              r_f0 <= 1'b1;
            end else begin
              r_keycode   <= w_next_key;
              r_key_valid <= (w_next_key != r_keycode);
              r_e0        <= 1'b0;
              r_f0        <= 1'b0;
            end
          end
        end
        default: r_state <= StIdle;
      endcase

      // A stalled partial frame is abandoned along with any pending prefix.
      if ((r_state != StIdle) && !w_bit_edge && (r_to_cnt == ToMax)) begin
        r_state     <= StIdle;
        r_frame_err <= 1'b1;
        r_e0        <= 1'b0;
        r_f0        <= 1'b0;
      end
    end
  end

  assign keycode   = r_keycode;
  assign key_valid = r_key_valid;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_ps2_keycode.sv
// Directed bench for ps2_keycode: drives PS/2 frames and checks keycode and pulse counts.
module tb_ps2_keycode;

  localparam int unsigned ToCycles = 200;

  logic       Clk;
  logic       Reset;
  logic       PS2_CLK;
  logic       PS2_DAT;
  logic [7:0] keycode;
  logic       key_valid;
  logic       frame_err;

  int n_tests = 0;
  int n_fail  = 0;
  int kv_cnt  = 0;
  int fe_cnt  = 0;
  int both_cnt = 0;

  ps2_keycode #(
    .TIMEOUT_CYCLES(ToCycles),
    .FILT_LEN      (4)
  ) u_dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .PS2_CLK  (PS2_CLK),
    .PS2_DAT  (PS2_DAT),
    .keycode  (keycode),
    .key_valid(key_valid),
    .frame_err(frame_err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (Reset) begin
      if (key_valid) kv_cnt <= kv_cnt + 1;
      if (frame_err) fe_cnt <= fe_cnt + 1;
      if (key_valid && frame_err) both_cnt <= both_cnt + 1;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: run exceeded time limit got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic send_bit(input logic b);
    PS2_DAT = b;
    wait_clk(10);
    PS2_CLK = 1'b0;
    wait_clk(20);
    PS2_CLK = 1'b1;
    wait_clk(10);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic flip_par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ flip_par);
    send_bit(stop);
    PS2_DAT = 1'b1;
    wait_clk(5);
  endtask

  task automatic send_partial(input int nbits);
    send_bit(1'b0);
    for (int i = 1; i < nbits; i++) send_bit(1'b1);
    PS2_DAT = 1'b1;
  endtask

  // One good frame; checks resulting keycode and pulse deltas.
  task automatic key_step(input string tag, input logic [7:0] b, input logic [7:0] exp_key,
                          input int exp_kv);
    int kv0;
    int fe0;
    kv0 = kv_cnt;
    fe0 = fe_cnt;
    send_frame(b, 1'b0, 1'b1);
    check_eq({tag, "_key"}, int'(keycode), int'(exp_key));
    check_eq({tag, "_kv"}, kv_cnt - kv0, exp_kv);
    check_eq({tag, "_fe"}, fe_cnt - fe0, 0);
  endtask

  int kv0;
  int fe0;

  initial begin
    Reset   = 1'b0;
    PS2_CLK = 1'b1;
    PS2_DAT = 1'b1;
    wait_clk(5);
    check_eq("rst_key", int'(keycode), 0);
    check_eq("rst_kv", int'(key_valid), 0);
    check_eq("rst_fe", int'(frame_err), 0);
    Reset = 1'b1;
    wait_clk(5);

    key_step("w_make", 8'h1D, 8'h1A, 1);
    key_step("f0_only", 8'hF0, 8'h1A, 0);
    key_step("w_break", 8'h1D, 8'h00, 1);

    key_step("a_make", 8'h1C, 8'h04, 1);
    key_step("d_make", 8'h23, 8'h07, 1);
    key_step("a_f0", 8'hF0, 8'h07, 0);
    key_step("a_break", 8'h1C, 8'h07, 0);

    key_step("e0_a", 8'hE0, 8'h07, 0);
    key_step("up_make", 8'h75, 8'h52, 1);
    key_step("e0_b", 8'hE0, 8'h52, 0);
    key_step("f0_b", 8'hF0, 8'h52, 0);
    key_step("up_break", 8'h75, 8'h00, 1);

    key_step("a_make2", 8'h1C, 8'h04, 1);
    key_step("lone_75", 8'h75, 8'h04, 0);
    key_step("typematic", 8'h1C, 8'h04, 0);
    key_step("space", 8'h29, 8'h2C, 1);
    key_step("f0_c", 8'hF0, 8'h2C, 0);
    key_step("other_brk", 8'h1C, 8'h2C, 0);

    kv0 = kv_cnt;
    fe0 = fe_cnt;
    send_frame(8'h1D, 1'b1, 1'b1);
    check_eq("par_fe", fe_cnt - fe0, 1);
    check_eq("par_key", int'(keycode), 8'h2C);
    check_eq("par_kv", kv_cnt - kv0, 0);
    fe0 = fe_cnt;
    send_frame(8'h1D, 1'b0, 1'b0);
    check_eq("stop_fe", fe_cnt - fe0, 1);
    check_eq("stop_key", int'(keycode), 8'h2C);

    fe0 = fe_cnt;
    send_bit(1'b1);
    wait_clk(5);
    check_eq("start_fe", fe_cnt - fe0, 1);

    fe0 = fe_cnt;
    send_partial(4);
    wait_clk(ToCycles / 2);
    check_eq("to_early", fe_cnt - fe0, 0);
    wait_clk(ToCycles);
    check_eq("to_fe", fe_cnt - fe0, 1);
    key_step("after_to", 8'h23, 8'h07, 1);

    key_step("e0_to", 8'hE0, 8'h07, 0);
    fe0 = fe_cnt;
    send_partial(4);
    wait_clk(ToCycles + 50);
    check_eq("to2_fe", fe_cnt - fe0, 1);
    key_step("e0_cleared", 8'h75, 8'h07, 0);

    send_partial(5);
    Reset = 1'b0;
    wait_clk(3);
    check_eq("midrst_key", int'(keycode), 0);
    Reset = 1'b1;
    wait_clk(5);
    key_step("post_rst", 8'h1D, 8'h1A, 1);

    check_eq("kv_fe_overlap", both_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
